// File: rtl/grid_pkg.sv
// Shared types and constants for the grid_map read-port arbiter.
package grid_pkg;

    localparam int unsigned GRID_DATA_W = 5;
    localparam int unsigned GRID_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // Saturating increment for the transaction timeout counter.
    function automatic logic [GRID_CNT_W-1:0] sat_inc(input logic [GRID_CNT_W-1:0] v);
        return (v == '1) ? v : GRID_CNT_W'(v + GRID_CNT_W'(1));
    endfunction

endpackage

// File: rtl/grid_req_slot.sv
// One requester slot: pending flag, latched address and overflow detect.
module grid_req_slot #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              clr,
    output logic              pending,
    output logic [ADDR_W-1:0] addr_lat,
    output logic              pending_next_c,
    output logic              overflow_c
);

    logic accept_c;

    // A request coinciding with the clear is accepted rather than dropped.
    always_comb begin
        accept_c       = req & (~pending | clr);
        overflow_c     = req & pending & ~clr;
        pending_next_c = accept_c | (pending & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            addr_lat <= '0;
        end else begin
            pending <= pending_next_c;
            if (accept_c) begin
                addr_lat <= addr;
            end
        end
    end

endmodule

// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing the grid_map read port between the DDA (A)
// and collision lookups (B); map switches are applied only while idle.
module grid_port_arbiter
    import grid_pkg::*;
#(
    parameter int unsigned N       = 24,
    parameter int unsigned ADDR_W  = $clog2(N * N),
    parameter int unsigned DATA_W  = GRID_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic [1:0]        map_select_in,
    output logic [1:0]        map_select_out,
    output logic              grid_req_out,
    output logic [ADDR_W-1:0] grid_addr_out,
    input  logic              grid_valid_in,
    input  logic [DATA_W-1:0] grid_data_in,
    output logic              busy_out,
    output logic              timeout_out,
    output logic              overflow_out
);

    arb_state_t            state, state_next;
    port_id_t              last_grant, last_grant_next;
    port_id_t              owner, owner_next;
    port_id_t              grant_c;
    logic [GRID_CNT_W-1:0] cnt, cnt_next;

    logic              pending_a, pending_b;
    logic              pend_next_a_c, pend_next_b_c;
    logic              ovf_a_c, ovf_b_c;
    logic              clr_a_c, clr_b_c;
    logic [ADDR_W-1:0] addr_lat_a, addr_lat_b;

    logic              done_c;
    logic [DATA_W-1:0] done_data_c;
    logic [1:0]        map_next;
    logic              grid_req_next;
    logic [ADDR_W-1:0] grid_addr_next;
    logic              valid_a_next, valid_b_next;
    logic [DATA_W-1:0] data_a_next, data_b_next;
    logic              timeout_next;
    logic              busy_next;

    grid_req_slot #(.ADDR_W(ADDR_W)) u_slot_a (
        .clk            (clk_in),
        .rst_n          (rst_in),
        .req            (req_a),
        .addr           (addr_a),
        .clr            (clr_a_c),
        .pending        (pending_a),
        .addr_lat       (addr_lat_a),
        .pending_next_c (pend_next_a_c),
        .overflow_c     (ovf_a_c)
    );

    grid_req_slot #(.ADDR_W(ADDR_W)) u_slot_b (
        .clk            (clk_in),
        .rst_n          (rst_in),
        .req            (req_b),
        .addr           (addr_b),
        .clr            (clr_b_c),
        .pending        (pending_b),
        .addr_lat       (addr_lat_b),
        .pending_next_c (pend_next_b_c),
        .overflow_c     (ovf_b_c)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        owner_next      = owner;
        grant_c         = PORT_A;
        cnt_next        = cnt;
        map_next        = map_select_out;
        grid_req_next   = 1'b0;
        grid_addr_next  = grid_addr_out;
        valid_a_next    = 1'b0;
        valid_b_next    = 1'b0;
        data_a_next     = data_a;
        data_b_next     = data_b;
        timeout_next    = 1'b0;
        clr_a_c         = 1'b0;
        clr_b_c         = 1'b0;
        done_c          = 1'b0;
        done_data_c     = '0;

        case (state)
            IDLE: begin
                if (map_select_in != map_select_out) begin
                    map_next = map_select_in;
                end else if (pending_a || pending_b) begin
                    if (pending_a && (!pending_b || last_grant == PORT_B)) begin
                        grant_c = PORT_A;
                    end else begin
                        grant_c = PORT_B;
                    end
                    owner_next      = grant_c;
                    last_grant_next = grant_c;
                    grid_addr_next  = (grant_c == PORT_A) ? addr_lat_a : addr_lat_b;
                    grid_req_next   = 1'b1;
                    cnt_next        = '0;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next = sat_inc(cnt);
                if (grid_valid_in) begin
                    done_c      = 1'b1;
                    done_data_c = grid_data_in;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = sat_inc(cnt);
                if (grid_valid_in) begin
                    done_c      = 1'b1;
                    done_data_c = grid_data_in;
                end else if (cnt == GRID_CNT_W'(TIMEOUT - 1)) begin
                    done_c       = 1'b1;
                    timeout_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Completion (data or abandoned) returns to the owning requester.
        if (done_c) begin
            state_next = IDLE;
            if (owner == PORT_A) begin
                valid_a_next = 1'b1;
                data_a_next  = done_data_c;
                clr_a_c      = 1'b1;
            end else begin
                valid_b_next = 1'b1;
                data_b_next  = done_data_c;
                clr_b_c      = 1'b1;
            end
        end
    end

    always_comb begin
        busy_next = (state_next != IDLE) | pend_next_a_c | pend_next_b_c;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            last_grant     <= PORT_B;
            owner          <= PORT_A;
            cnt            <= '0;
            map_select_out <= '0;
            grid_req_out   <= 1'b0;
            grid_addr_out  <= '0;
            valid_a        <= 1'b0;
            valid_b        <= 1'b0;
            data_a         <= '0;
            data_b         <= '0;
            timeout_out    <= 1'b0;
            busy_out       <= 1'b0;
            overflow_out   <= 1'b0;
        end else begin
            last_grant     <= last_grant_next;
            owner          <= owner_next;
            cnt            <= cnt_next;
            map_select_out <= map_next;
            grid_req_out   <= grid_req_next;
            grid_addr_out  <= grid_addr_next;
            valid_a        <= valid_a_next;
            valid_b        <= valid_b_next;
            data_a         <= data_a_next;
            data_b         <= data_b_next;
            timeout_out    <= timeout_next;
            busy_out       <= busy_next;
            overflow_out   <= overflow_out | ovf_a_c | ovf_b_c;
        end
    end

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Scoreboard bench for grid_port_arbiter with a 2-cycle grid_map model
// that returns addr % 17.
module tb_grid_port_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 5;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    map;
        int            cyc;
    } issue_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        logic          to;
        int            cyc;
    } resp_t;

    typedef enum int {P_BUSY, P_MAP, P_OVF, P_REQ, P_DATA_B, P_TMO, P_ZERO} probe_sig_e;

    typedef struct {
        int          cyc;
        probe_sig_e  sig;
        logic [31:0] exp;
    } probe_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          req_a, req_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          valid_a, valid_b;
    logic [DW-1:0] data_a, data_b;
    logic [1:0]    map_select_in, map_select_out;
    logic          grid_req_out;
    logic [AW-1:0] grid_addr_out;
    logic          grid_valid_in;
    logic [DW-1:0] grid_data_in;
    logic          busy_out, timeout_out, overflow_out;

    logic          model_valid = 1'b0;
    logic [DW-1:0] model_data  = '0;
    logic          force_valid;
    logic [DW-1:0] force_data;
    logic          mem_en;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    issue_t issue_q[$];
    resp_t  resp_q[$];
    probe_t probe_q[$];

    assign grid_valid_in = model_valid | force_valid;
    assign grid_data_in  = model_valid ? model_data : force_data;

    grid_port_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_a          (req_a),
        .req_b          (req_b),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .valid_a        (valid_a),
        .valid_b        (valid_b),
        .data_a         (data_a),
        .data_b         (data_b),
        .map_select_in  (map_select_in),
        .map_select_out (map_select_out),
        .grid_req_out   (grid_req_out),
        .grid_addr_out  (grid_addr_out),
        .grid_valid_in  (grid_valid_in),
        .grid_data_in   (grid_data_in),
        .busy_out       (busy_out),
        .timeout_out    (timeout_out),
        .overflow_out   (overflow_out)
    );

    initial forever #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // grid_map model: response in the second cycle after the ISSUE cycle.
    initial begin
        int cd;
        logic [AW-1:0] pend_addr;
        cd = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk_in);
            model_valid = 1'b0;
            if (cd != 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    model_valid = 1'b1;
                    model_data  = DW'(pend_addr % 17);
                end
            end
            if (grid_req_out && mem_en) begin
                cd = 2;
                pend_addr = grid_addr_out;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] probe_val(input probe_sig_e s);
        case (s)
            P_BUSY:   return 32'(busy_out);
            P_MAP:    return 32'(map_select_out);
            P_OVF:    return 32'(overflow_out);
            P_REQ:    return 32'(grid_req_out);
            P_DATA_B: return 32'(data_b);
            P_TMO:    return 32'(timeout_out);
            default:  return 32'({valid_a, valid_b, data_a, data_b, map_select_out, grid_req_out,
                                  grid_addr_out, busy_out, timeout_out, overflow_out});
        endcase
    endfunction

    function automatic string probe_name(input probe_sig_e s);
        case (s)
            P_BUSY:   return "busy_out";
            P_MAP:    return "map_select_out";
            P_OVF:    return "overflow_out";
            P_REQ:    return "grid_req_out";
            P_DATA_B: return "data_b";
            P_TMO:    return "timeout_out";
            default:  return "all_outputs_zero";
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT presents an output.
    initial begin
        issue_t ie;
        resp_t  re;
        forever begin
            @(negedge clk_in);
            if (grid_req_out) begin
                if (issue_q.size() == 0) begin
                    check("unexpected_issue", 32'(grid_req_out), 32'd0);
                end else begin
                    ie = issue_q.pop_front();
                    check("issue_addr", 32'(grid_addr_out), 32'(ie.addr));
                    check("issue_map", 32'(map_select_out), 32'(ie.map));
                    check("issue_cycle", 32'(cyc), 32'(ie.cyc));
                end
            end
            if (issue_q.size() != 0 && issue_q[0].cyc < cyc) begin
                check("missing_issue", 32'(cyc), 32'(issue_q[0].cyc));
                void'(issue_q.pop_front());
            end

            if (valid_a || valid_b) begin
                check("single_valid", 32'(valid_a & valid_b), 32'd0);
                if (resp_q.size() == 0) begin
                    check("unexpected_response", 32'({valid_a, valid_b}), 32'd0);
                end else begin
                    re = resp_q.pop_front();
                    check("resp_port", 32'(valid_b), 32'(re.port));
                    check("resp_data", 32'(valid_b ? data_b : data_a), 32'(re.data));
                    check("resp_timeout", 32'(timeout_out), 32'(re.to));
                    check("resp_cycle", 32'(cyc), 32'(re.cyc));
                end
            end else if (timeout_out) begin
                check("stray_timeout", 32'(timeout_out), 32'd0);
            end
            if (resp_q.size() != 0 && resp_q[0].cyc < cyc) begin
                check("missing_response", 32'(cyc), 32'(resp_q[0].cyc));
                void'(resp_q.pop_front());
            end

            for (int i = int'(probe_q.size()) - 1; i >= 0; i--) begin
                if (probe_q[i].cyc <= cyc) begin
                    check(probe_name(probe_q[i].sig), probe_val(probe_q[i].sig), probe_q[i].exp);
                    probe_q.delete(i);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    function automatic void exp_issue(input int a, input int m, input int c);
        issue_q.push_back('{addr: AW'(a), map: 2'(m), cyc: c});
    endfunction

    function automatic void exp_resp(input int p, input int d, input int to, input int c);
        resp_q.push_back('{port: 1'(p), data: DW'(d), to: 1'(to), cyc: c});
    endfunction

    function automatic void probe(input int c, input probe_sig_e s, input int e);
        probe_q.push_back('{cyc: c, sig: s, exp: 32'(e)});
    endfunction

    task automatic do_reset();
        rst_in = 1'b0;
        repeat (2) tick();
        probe(cyc + 1, P_ZERO, 0);
        rst_in = 1'b1;
        tick();
    endtask

    initial begin
        int c;
        rst_in = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        addr_a = '0;
        addr_b = '0;
        map_select_in = 2'd0;
        force_valid = 1'b0;
        force_data = '0;
        mem_en = 1'b1;
        repeat (2) tick();
        do_reset();

        // Single request A, addr 37 -> data 3.
        tick();
        c = cyc;
        req_a = 1'b1; addr_a = AW'(37);
        exp_issue(37, 0, c + 2);
        exp_resp(0, 3, 0, c + 5);
        probe(c + 1, P_BUSY, 1);
        probe(c + 4, P_BUSY, 1);
        probe(c + 5, P_BUSY, 0);
        tick();
        req_a = 1'b0;
        repeat (6) tick();

        // Simultaneous A+B from reset: A first, then alternation holds.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            c = cyc;
            req_a = 1'b1; addr_a = AW'(10);
            req_b = 1'b1; addr_b = AW'(20);
            exp_issue(10, 0, c + 2);
            exp_resp(0, 10, 0, c + 5);
            exp_issue(20, 0, c + 6);
            exp_resp(1, 3, 0, c + 9);
            tick();
            req_a = 1'b0; req_b = 1'b0;
            repeat (9) tick();
        end

        // Map change during WAIT applies in IDLE before B's grant.
        c = cyc;
        req_a = 1'b1; addr_a = AW'(37);
        req_b = 1'b1; addr_b = AW'(20);
        exp_issue(37, 0, c + 2);
        exp_resp(0, 3, 0, c + 5);
        exp_issue(20, 2, c + 7);
        exp_resp(1, 3, 0, c + 10);
        probe(c + 4, P_MAP, 0);
        probe(c + 5, P_MAP, 0);
        probe(c + 6, P_MAP, 2);
        tick();
        req_a = 1'b0; req_b = 1'b0;
        repeat (2) tick();
        map_select_in = 2'd2;
        repeat (8) tick();

        // grid_map silent: B abandoned after 15 ISSUE+WAIT cycles.
        mem_en = 1'b0;
        c = cyc;
        req_b = 1'b1; addr_b = AW'(5);
        exp_issue(5, 2, c + 2);
        exp_resp(1, 0, 1, c + 17);
        probe(c + 16, P_BUSY, 1);
        probe(c + 17, P_BUSY, 0);
        probe(c + 18, P_TMO, 0);
        probe(c + 18, P_DATA_B, 0);
        probe(c + 21, P_DATA_B, 0);
        probe(c + 21, P_BUSY, 0);
        tick();
        req_b = 1'b0;
        while (cyc < c + 19) tick();
        force_valid = 1'b1; force_data = DW'(31);
        tick();
        force_valid = 1'b0;
        repeat (3) tick();
        mem_en = 1'b1;

        // Second req_b while B pending is dropped and flagged.
        c = cyc;
        req_a = 1'b1; addr_a = AW'(10);
        exp_issue(10, 2, c + 2);
        exp_resp(0, 10, 0, c + 5);
        exp_issue(5, 2, c + 6);
        exp_resp(1, 5, 0, c + 9);
        probe(c + 3, P_OVF, 0);
        probe(c + 4, P_OVF, 1);
        probe(c + 12, P_OVF, 1);
        tick();
        req_a = 1'b0;
        req_b = 1'b1; addr_b = AW'(5);
        tick();
        req_b = 1'b0;
        tick();
        req_b = 1'b1; addr_b = AW'(99);
        tick();
        req_b = 1'b0;
        repeat (9) tick();

        // Reset during WAIT clears outputs before the next edge.
        c = cyc;
        req_a = 1'b1; addr_a = AW'(37);
        exp_issue(37, 2, c + 2);
        probe(c + 3, P_ZERO, 0);
        tick();
        req_a = 1'b0;
        tick();
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (3) tick();
        rst_in = 1'b1;
        for (int k = c + 6; k <= c + 16; k++) probe(k, P_REQ, 0);
        probe(c + 10, P_BUSY, 0);
        repeat (13) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
